pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives stall/flush of PC, IF/ID, ID/EX, EX/MEM.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 13 +
 rtl/hazard_perf_counter.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FREEZE   = 2'd1,
        ST_REDIRECT = 2'd2
    } hz_state_e;

    localparam int          RDR_CNT_W = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter, cleared by synchronous reset.
module hazard_perf_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // Count enabled cycles, holding at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (en_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_q <= count_q;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W      = 5,
    parameter int unsigned REDIRECT_CYCLES = 1,
    parameter int unsigned PERF_CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_mispredict_i,
    input  logic                  imem_ready_i,
    input  logic                  dmem_busy_i,
    input  logic                  md_busy_i,
    output logic                  pc_stall_o,
    output logic                  if_id_stall_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_stall_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_stall_o,
    output logic [1:0]            state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles_o,
    output logic [PERF_CNT_W-1:0] flush_cycles_o
`endif
);

    hz_state_e              state_q, state_d;
    logic [RDR_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   busy_s;
    logic                   load_use_s;

    assign busy_s     = dmem_busy_i | md_busy_i;
    assign load_use_s = ex_mem_read_i && (ex_rd_i != {REG_ADDR_W{1'b0}}) &&
                        ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                         (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    // Priority mux: busy freeze, mispredict, redirect drain, load-use, fetch miss.
    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        state_d        = state_q;
        cnt_d          = cnt_q;
        if (busy_s) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
            state_d        = ST_FREEZE;
        end else if (ex_mispredict_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            if (REDIRECT_CYCLES > 0) begin
                state_d = ST_REDIRECT;
                cnt_d   = RDR_CNT_W'(REDIRECT_CYCLES);
            end else begin
                state_d = ST_RUN;
                cnt_d   = {RDR_CNT_W{1'b0}};
            end
        end else if ((state_q == ST_REDIRECT) ||
                     ((state_q == ST_FREEZE) && (cnt_q != {RDR_CNT_W{1'b0}}))) begin
            if_id_flush_o = 1'b1;
            // Guard against a zero count so the drain can never wrap.
            if (cnt_q <= {{(RDR_CNT_W-1){1'b0}}, 1'b1}) begin
                state_d = ST_RUN;
                cnt_d   = {RDR_CNT_W{1'b0}};
            end else begin
                state_d = ST_REDIRECT;
                cnt_d   = cnt_q - {{(RDR_CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (load_use_s) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
            state_d       = ST_RUN;
        end else if (!imem_ready_i) begin
            pc_stall_o    = 1'b1;
            if_id_flush_o = 1'b1;
            state_d       = ST_RUN;
        end else begin
            state_d = ST_RUN;
        end
    end

    // State and redirect counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= {RDR_CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter #(.W(PERF_CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (pc_stall_o),
        .count_o (stall_cycles_o)
    );

    hazard_perf_counter #(.W(PERF_CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (if_id_flush_o),
        .count_o (flush_cycles_o)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (REDIRECT_CYCLES=2).
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       use_rs1, use_rs2, mem_read, mispredict, imem_ready, dmem_busy, md_busy;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
    logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
    logic [3:0] stall_cycles, flush_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] v;
        string      tag;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W      (5),
        .REDIRECT_CYCLES (2),
        .PERF_CNT_W      (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1_i        (id_rs1),
        .id_rs2_i        (id_rs2),
        .id_use_rs1_i    (use_rs1),
        .id_use_rs2_i    (use_rs2),
        .ex_rd_i         (ex_rd),
        .ex_mem_read_i   (mem_read),
        .ex_mispredict_i (mispredict),
        .imem_ready_i    (imem_ready),
        .dmem_busy_i     (dmem_busy),
        .md_busy_i       (md_busy),
        .pc_stall_o      (pc_stall),
        .if_id_stall_o   (if_id_stall),
        .if_id_flush_o   (if_id_flush),
        .id_ex_stall_o   (id_ex_stall),
        .id_ex_flush_o   (id_ex_flush),
        .ex_mem_stall_o  (ex_mem_stall),
        .state_o         (state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles_o  (stall_cycles),
        .flush_cycles_o  (flush_cycles)
`endif
    );

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, state}
    function automatic logic [7:0] mk(input logic ps, input logic is, input logic ifl,
                                      input logic es, input logic efl, input logic ms,
                                      input logic [1:0] st);
        return {ps, is, ifl, es, efl, ms, st};
    endfunction

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        use_rs1 = 1'b0; use_rs2 = 1'b0; mem_read = 1'b0; mispredict = 1'b0;
        imem_ready = 1'b1; dmem_busy = 1'b0; md_busy = 1'b0;
    endtask

    // Push expectation for the inputs just driven, then pop and compare once settled.
    task automatic step(input logic [7:0] exp_v, input string tag);
        exp_t e;
        logic [7:0] obs;
        e.v = exp_v;
        e.tag = tag;
        exp_q.push_back(e);
        #2;
        e = exp_q.pop_front();
        obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, state};
        checks++;
        assert (obs === e.v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(mk(0,0,0,0,0,0,2'd0), "reset_state");

        mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; use_rs1 = 1'b1;
        step(mk(1,1,0,0,1,0,2'd0), "load_use_rs1");
        idle();
        step(mk(0,0,0,0,0,0,2'd0), "load_use_one_cycle");
        mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; use_rs1 = 1'b1;
        step(mk(0,0,0,0,0,0,2'd0), "load_use_rd0");
        mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; use_rs2 = 1'b1; id_rs1 = 5'd3;
        step(mk(1,1,0,0,1,0,2'd0), "load_use_rs2");
        use_rs2 = 1'b0;
        step(mk(0,0,0,0,0,0,2'd0), "no_use_no_stall");
        idle();
        mem_read = 1'b0; ex_rd = 5'd4; id_rs1 = 5'd4; use_rs1 = 1'b1;
        step(mk(0,0,0,0,0,0,2'd0), "not_load");
        idle();
        imem_ready = 1'b0;
        step(mk(1,0,1,0,0,0,2'd0), "imem_miss");
        mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; use_rs1 = 1'b1;
        step(mk(1,1,0,0,1,0,2'd0), "imem_miss_and_load_use");

        idle();
        mispredict = 1'b1;
        step(mk(0,0,1,0,1,0,2'd0), "mispredict");
        idle();
        step(mk(0,0,1,0,0,0,2'd2), "redirect_1");
        step(mk(0,0,1,0,0,0,2'd2), "redirect_2");
        step(mk(0,0,0,0,0,0,2'd0), "redirect_done");

        mispredict = 1'b1;
        step(mk(0,0,1,0,1,0,2'd0), "mispredict_b");
        idle();
        step(mk(0,0,1,0,0,0,2'd2), "redirect_cnt2");
        md_busy = 1'b1;
        step(mk(1,1,0,1,0,1,2'd2), "busy_in_redirect");
        for (int i = 0; i < 3; i++) step(mk(1,1,0,1,0,1,2'd1), "busy_freeze");
        md_busy = 1'b0;
        step(mk(0,0,1,0,0,0,2'd1), "freeze_exit_flush");
        step(mk(0,0,0,0,0,0,2'd0), "freeze_exit_run");

        mispredict = 1'b1; dmem_busy = 1'b1;
        step(mk(1,1,0,1,0,1,2'd0), "mispredict_with_busy");
        dmem_busy = 1'b0;
        step(mk(0,0,1,0,1,0,2'd1), "busy_drop_mispredict");
        idle();
        step(mk(0,0,1,0,0,0,2'd2), "late_redirect_1");
        step(mk(0,0,1,0,0,0,2'd2), "late_redirect_2");
        step(mk(0,0,0,0,0,0,2'd0), "late_redirect_done");

        mispredict = 1'b1;
        step(mk(0,0,1,0,1,0,2'd0), "mispredict_c");
        idle();
        reset = 1'b1;
        step(mk(0,0,1,0,0,0,2'd2), "reset_cycle_in_redirect");
        reset = 1'b0;
        step(mk(0,0,0,0,0,0,2'd0), "reset_from_redirect");

`ifdef HAZARD_PERF_CNT_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);
        idle();
        checks++;
        assert (stall_cycles === 4'd15) else begin
            failures++;
            $error("FAIL perf_stall_sat observed=%0d expected=15", stall_cycles);
        end
        checks++;
        assert (flush_cycles === 4'd15) else begin
            failures++;
            $error("FAIL perf_flush_sat observed=%0d expected=15", flush_cycles);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
